// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: load-use stalls, mispredict flushes, JALR target waits
// and the decode-stage handshake with the encryption accelerator.
module hazard_sched #(
    parameter int unsigned ENC_TIMEOUT = 255,
    parameter logic [6:0]  ENC_OPCODE  = 7'b0001011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [6:0] id_op,
    input  logic       id_flag,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_wen,
    input  logic       ex_is_load,
    input  logic       ex_mispredict,
    input  logic       jalr_resolved,
    input  logic       enc_done,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_fd,
    output logic       bubble_e,
    output logic       enc_start,
    output logic       enc_abort,
    output logic       enc_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        JALR_WAIT = 3'd1,
        ENC_START = 3'd2,
        ENC_WAIT  = 3'd3,
        ENC_REL   = 3'd4
    } state_t;

    localparam logic [6:0] JALR_OPCODE  = 7'b1100111;
    localparam logic [7:0] TIMEOUT_LAST = 8'(ENC_TIMEOUT - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [7:0] enc_cnt_r;
    logic       enc_err_r;
    logic       cnt_clr_s;
    logic       cnt_inc_s;
    logic       err_set_s;
    logic       load_use_s;
    logic       jalr_s;
    logic       enc_s;

    assign load_use_s = id_valid & ex_is_load & ex_wen & (ex_rd != 5'd0)
                      & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign jalr_s     = id_valid & (id_op == JALR_OPCODE) & ~id_flag;
    assign enc_s      = id_valid & (id_op == ENC_OPCODE);

    assign state   = state_r;
    assign enc_err = enc_err_r;

    // Next-state and combinational pipeline control from current state and inputs
    always_comb begin
        next_state_s = state_r;
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        flush_fd     = 1'b0;
        bubble_e     = 1'b0;
        enc_start    = 1'b0;
        enc_abort    = 1'b0;
        cnt_clr_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            RUN: begin
                if (ex_mispredict) begin
                    flush_fd     = 1'b1;
                    bubble_e     = 1'b1;
                    next_state_s = RUN;
                end else if (load_use_s) begin
                    stall_f      = 1'b1;
                    stall_d      = 1'b1;
                    bubble_e     = 1'b1;
                    next_state_s = RUN;
                end else if (jalr_s) begin
                    stall_f      = 1'b1;
                    flush_fd     = 1'b1;
                    next_state_s = JALR_WAIT;
                end else if (enc_s) begin
                    stall_f      = 1'b1;
                    stall_d      = 1'b1;
                    bubble_e     = 1'b1;
                    next_state_s = ENC_START;
                end else begin
                    next_state_s = RUN;
                end
            end
            JALR_WAIT: begin
                flush_fd = 1'b1;
                if (ex_mispredict) begin
                    bubble_e     = 1'b1;
                    next_state_s = RUN;
                end else if (jalr_resolved) begin
                    next_state_s = RUN;
                end else begin
                    stall_f      = 1'b1;
                    next_state_s = JALR_WAIT;
                end
            end
            ENC_START: begin
                if (ex_mispredict) begin
                    flush_fd     = 1'b1;
                    bubble_e     = 1'b1;
                    enc_abort    = 1'b1;
                    next_state_s = RUN;
                end else begin
                    enc_start    = 1'b1;
                    stall_f      = 1'b1;
                    stall_d      = 1'b1;
                    bubble_e     = 1'b1;
                    cnt_clr_s    = 1'b1;
                    next_state_s = ENC_WAIT;
                end
            end
            ENC_WAIT: begin
                if (ex_mispredict) begin
                    flush_fd     = 1'b1;
                    bubble_e     = 1'b1;
                    enc_abort    = 1'b1;
                    next_state_s = RUN;
                end else begin
                    stall_f   = 1'b1;
                    stall_d   = 1'b1;
                    bubble_e  = 1'b1;
                    cnt_inc_s = 1'b1;
                    // Completion outranks a timeout landing in the same cycle
                    if (enc_done) begin
                        next_state_s = ENC_REL;
                    end else if (enc_cnt_r == TIMEOUT_LAST) begin
                        enc_abort    = 1'b1;
                        err_set_s    = 1'b1;
                        next_state_s = ENC_REL;
                    end else begin
                        next_state_s = ENC_WAIT;
                    end
                end
            end
            ENC_REL: begin
                // Instruction leaves decode here; skipping detection stops a re-trigger
                if (ex_mispredict) begin
                    flush_fd = 1'b1;
                    bubble_e = 1'b1;
                end else begin
                    flush_fd = 1'b0;
                end
                next_state_s = RUN;
            end
            default: begin
                next_state_s = RUN;
            end
        endcase
    end

    // State, timeout counter and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= RUN;
            enc_cnt_r <= 8'd0;
            enc_err_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (cnt_clr_s) begin
                enc_cnt_r <= 8'd0;
            end else if (cnt_inc_s && (enc_cnt_r != 8'hFF)) begin
                enc_cnt_r <= enc_cnt_r + 8'd1;
            end else begin
                enc_cnt_r <= enc_cnt_r;
            end
            if (err_set_s) begin
                enc_err_r <= 1'b1;
            end else begin
                enc_err_r <= enc_err_r;
            end
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: a default-timeout instance and a
// timeout-4 instance share stimulus; each expectation names which one it checks.
module tb_hazard_sched;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [6:0] id_op;
    logic       id_flag;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rd;
    logic       ex_wen;
    logic       ex_is_load;
    logic       ex_mispredict;
    logic       jalr_resolved;
    logic       enc_done;

    logic       sf0, sd0, ff0, be0, es0, ea0, er0;
    logic [2:0] st0;
    logic       sf1, sd1, ff1, be1, es1, ea1, er1;
    logic [2:0] st1;

    hazard_sched dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_flag(id_flag),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_wen(ex_wen),
        .ex_is_load(ex_is_load), .ex_mispredict(ex_mispredict),
        .jalr_resolved(jalr_resolved), .enc_done(enc_done),
        .stall_f(sf0), .stall_d(sd0), .flush_fd(ff0), .bubble_e(be0),
        .enc_start(es0), .enc_abort(ea0), .enc_err(er0), .state(st0)
    );

    hazard_sched #(.ENC_TIMEOUT(4)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_flag(id_flag),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_wen(ex_wen),
        .ex_is_load(ex_is_load), .ex_mispredict(ex_mispredict),
        .jalr_resolved(jalr_resolved), .enc_done(enc_done),
        .stall_f(sf1), .stall_d(sd1), .flush_fd(ff1), .bubble_e(be1),
        .enc_start(es1), .enc_abort(ea1), .enc_err(er1), .state(st1)
    );

    typedef struct {
        logic [9:0] exp;
        bit         sel;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are valid every cycle, so pop one expectation per falling edge
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [9:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = e.sel ? {sf1, sd1, ff1, be1, es1, ea1, er1, st1}
                        : {sf0, sd0, ff0, be0, es0, ea0, er0, st0};
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got sf,sd,ff,be,es,ea,er,st=%b expected %b", e.name, act, e.exp);
            end
        end
    end

    // f = {stall_f, stall_d, flush_fd, bubble_e, enc_start, enc_abort, enc_err}
    task automatic step(input logic [6:0] f, input logic [2:0] st, input bit sel, input string nm);
        sb.push_back('{exp: {f, st}, sel: sel, name: nm});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_valid = 1'b0; id_op = 7'd0; id_flag = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        ex_rd = 5'd0; ex_wen = 1'b0; ex_is_load = 1'b0; ex_mispredict = 1'b0;
        jalr_resolved = 1'b0; enc_done = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    task automatic set_enc();
        id_valid = 1'b1; id_op = 7'b0001011;
    endtask

    task automatic set_jalr();
        id_valid = 1'b1; id_op = 7'b1100111; id_flag = 1'b0;
    endtask

    task automatic set_lu();
        id_valid = 1'b1; id_rs2 = 5'd5; ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd5;
    endtask

    initial begin
        clr();
        do_reset();
        step(7'b0000000, 3'd0, 1'b0, "reset_idle0");
        step(7'b0000000, 3'd0, 1'b1, "reset_idle1");

        // Load-use on rs2, then the same with ex_rd=x0, then a non-matching rs1
        set_lu();
        step(7'b1101000, 3'd0, 1'b0, "load_use_rs2");
        ex_rd = 5'd0;
        step(7'b0000000, 3'd0, 1'b0, "load_use_x0");
        clr(); set_lu(); id_rs2 = 5'd6; id_rs1 = 5'd5;
        step(7'b1101000, 3'd0, 1'b0, "load_use_rs1");
        ex_is_load = 1'b0;
        step(7'b0000000, 3'd0, 1'b0, "no_load_alu");

        // Resolved JALR and stray handshakes in RUN are ignored
        clr(); set_jalr(); id_flag = 1'b1;
        step(7'b0000000, 3'd0, 1'b0, "jalr_resolved_dec");
        clr(); jalr_resolved = 1'b1; enc_done = 1'b1;
        step(7'b0000000, 3'd0, 1'b0, "stray_handshakes");

        // JALR wait, resolved on the third JALR_WAIT cycle
        clr(); set_jalr();
        step(7'b1010000, 3'd0, 1'b0, "jalr_detect");
        clr();
        step(7'b1010000, 3'd1, 1'b0, "jalr_wait1");
        step(7'b1010000, 3'd1, 1'b0, "jalr_wait2");
        jalr_resolved = 1'b1;
        step(7'b0010000, 3'd1, 1'b0, "jalr_resolve");
        clr();
        step(7'b0000000, 3'd0, 1'b0, "jalr_back_run");

        // Encryption, enc_done on the 5th ENC_WAIT cycle
        set_enc();
        step(7'b1101000, 3'd0, 1'b0, "enc_detect");
        step(7'b1101100, 3'd2, 1'b0, "enc_start");
        for (int i = 0; i < 4; i++) step(7'b1101000, 3'd3, 1'b0, "enc_wait");
        enc_done = 1'b1;
        step(7'b1101000, 3'd3, 1'b0, "enc_wait_done");
        enc_done = 1'b0;
        step(7'b0000000, 3'd4, 1'b0, "enc_rel");
        clr();
        step(7'b0000000, 3'd0, 1'b0, "enc_back_run");
        do_reset();

        // Timeout on the 4-cycle instance; error is sticky until rst
        set_enc();
        step(7'b1101000, 3'd0, 1'b1, "to_detect");
        step(7'b1101100, 3'd2, 1'b1, "to_start");
        for (int i = 0; i < 3; i++) step(7'b1101000, 3'd3, 1'b1, "to_wait");
        step(7'b1101010, 3'd3, 1'b1, "to_abort");
        step(7'b0000001, 3'd4, 1'b1, "to_rel_err");
        clr();
        step(7'b0000001, 3'd0, 1'b1, "to_err_sticky1");
        step(7'b0000001, 3'd0, 1'b1, "to_err_sticky2");
        rst = 1'b1;
        step(7'b0000001, 3'd0, 1'b1, "to_err_in_rst");
        rst = 1'b0;
        step(7'b0000000, 3'd0, 1'b1, "to_err_cleared");

        // enc_done coincident with the timeout cycle wins
        set_enc();
        step(7'b1101000, 3'd0, 1'b1, "tie_detect");
        step(7'b1101100, 3'd2, 1'b1, "tie_start");
        for (int i = 0; i < 3; i++) step(7'b1101000, 3'd3, 1'b1, "tie_wait");
        enc_done = 1'b1;
        step(7'b1101000, 3'd3, 1'b1, "tie_done_wins");
        enc_done = 1'b0;
        step(7'b0000000, 3'd4, 1'b1, "tie_rel_no_err");
        clr();
        step(7'b0000000, 3'd0, 1'b1, "tie_back_run");
        do_reset();

        // Mispredict outranks concurrent JALR and load-use
        set_jalr(); id_rs1 = 5'd5; ex_rd = 5'd5; ex_wen = 1'b1; ex_is_load = 1'b1;
        ex_mispredict = 1'b1;
        step(7'b0011000, 3'd0, 1'b0, "mp_priority");
        clr();
        step(7'b0000000, 3'd0, 1'b0, "mp_stay_run");

        // Mispredict in JALR_WAIT
        set_jalr();
        step(7'b1010000, 3'd0, 1'b0, "mpj_detect");
        clr(); ex_mispredict = 1'b1;
        step(7'b0011000, 3'd1, 1'b0, "mpj_flush");
        clr();
        step(7'b0000000, 3'd0, 1'b0, "mpj_run");

        // Mispredict in ENC_START suppresses enc_start
        set_enc();
        step(7'b1101000, 3'd0, 1'b0, "mps_detect");
        ex_mispredict = 1'b1;
        step(7'b0011010, 3'd2, 1'b0, "mps_abort");
        clr();
        step(7'b0000000, 3'd0, 1'b0, "mps_run");

        // Mispredict in ENC_WAIT aborts without setting the error
        set_enc();
        step(7'b1101000, 3'd0, 1'b0, "mpw_detect");
        step(7'b1101100, 3'd2, 1'b0, "mpw_start");
        step(7'b1101000, 3'd3, 1'b0, "mpw_wait");
        ex_mispredict = 1'b1;
        step(7'b0011010, 3'd3, 1'b0, "mpw_abort");
        clr();
        step(7'b0000000, 3'd0, 1'b0, "mpw_run_no_err");

        // Mispredict in ENC_REL
        set_enc();
        step(7'b1101000, 3'd0, 1'b0, "mpr_detect");
        step(7'b1101100, 3'd2, 1'b0, "mpr_start");
        enc_done = 1'b1;
        step(7'b1101000, 3'd3, 1'b0, "mpr_done");
        enc_done = 1'b0; ex_mispredict = 1'b1;
        step(7'b0011000, 3'd4, 1'b0, "mpr_flush");
        clr();
        step(7'b0000000, 3'd0, 1'b0, "mpr_run");

        // Reset mid-ENC_WAIT with the counter at 7: no abort, everything cleared
        do_reset();
        set_enc();
        step(7'b1101000, 3'd0, 1'b0, "rw_detect");
        step(7'b1101100, 3'd2, 1'b0, "rw_start");
        for (int i = 0; i < 7; i++) step(7'b1101000, 3'd3, 1'b0, "rw_wait");
        rst = 1'b1;
        step(7'b1101000, 3'd3, 1'b0, "rw_rst_no_abort");
        rst = 1'b0;
        checks++;
        if (dut0.enc_cnt_r !== 8'd0) begin
            failures++;
            $display("FAIL rw_counter: got %0d expected 0", dut0.enc_cnt_r);
        end
        clr();
        step(7'b0000000, 3'd0, 1'b0, "rw_after_rst");

        idle();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
